// File: rtl/seg_scan_arbiter.sv
// Eight-digit multiplexed 7-segment driver: round-robin shared write port into the digit
// buffer, programmable slot timing and a blanking window at the start of every slot.
module seg_scan_arbiter #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [2:0] a_addr,
    input  logic [7:0] a_data,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [2:0] b_addr,
    input  logic [7:0] b_data,
    input  logic       blank_all,
    output logic [7:0] segout,
    output logic [2:0] scanout,
    output logic       frame_done
);

    localparam int unsigned     CntW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYC);

    typedef enum logic {RrA, RrB} rr_e;

    rr_e             rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]      scan_q, scan_d;
    logic            frame_done_q, frame_done_d;
    logic            blank_q;
    logic [7:0]      mem_q [8];

    logic            wrap;
    logic            wr_en;
    logic [2:0]      wr_addr;
    logic [7:0]      wr_data;

    // Arbiter: contention is resolved by rr_ptr, which only advances when both sides asked.
    always_comb begin
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        rr_ptr_d = rr_ptr_q;
        if (!reset) begin
            if (a_valid && b_valid) begin
                if (rr_ptr_q == RrA) begin
                    a_ready  = 1'b1;
                    rr_ptr_d = RrB;
                end else begin
                    b_ready  = 1'b1;
                    rr_ptr_d = RrA;
                end
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    always_comb begin
        wr_en   = a_ready || b_ready;
        wr_addr = a_ready ? a_addr : b_addr;
        wr_data = a_ready ? a_data : b_data;
    end

    always_comb begin
        wrap         = (div_cnt_q == CntLast);
        div_cnt_d    = wrap ? '0 : div_cnt_q + CntW'(1);
        scan_d       = wrap ? scan_q + 3'd1 : scan_q;
        // Registered so the pulse lands on the first cycle that actually shows digit 0.
        frame_done_d = wrap && (scan_q == 3'd7);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q    <= '0;
            scan_q       <= 3'd0;
            frame_done_q <= 1'b0;
            blank_q      <= 1'b0;
            rr_ptr_q     <= RrA;
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= 8'hFF;
            end
        end else begin
            div_cnt_q    <= div_cnt_d;
            scan_q       <= scan_d;
            frame_done_q <= frame_done_d;
            blank_q      <= blank_all;
            rr_ptr_q     <= rr_ptr_d;
            if (wr_en) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

    // Driven purely from state, so pin timing never depends on requester inputs.
    assign segout     = (blank_q || (div_cnt_q < BlankEnd)) ? 8'hFF : mem_q[scan_q];
    assign scanout    = scan_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Scoreboard bench for seg_scan_arbiter: a time-based reference model predicts every cycle's
// outputs into a queue, and a separate monitor pops and compares them on the falling edge.
module tb_seg_scan_arbiter;

    localparam int unsigned SD = 8;
    localparam int unsigned BC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_valid, a_ready, b_valid, b_ready;
    logic [2:0] a_addr, b_addr, scanout;
    logic [7:0] a_data, b_data, segout;
    logic       blank_all, frame_done;

    seg_scan_arbiter #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .blank_all  (blank_all),
        .segout     (segout),
        .scanout    (scanout),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       a_rdy;
        logic       b_rdy;
        logic [7:0] seg;
        logic [2:0] scan;
        logic       fd;
    } obs_t;

    typedef struct {
        obs_t        v;
        int          scen;
        int unsigned t;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   scen  = 0;

    // Reference model: display position is a pure function of cycles since reset.
    int unsigned t;
    logic [7:0]  ref_mem [8];
    bit          ref_blank;
    bit          owed_b;
    bit          a_fire, b_fire;

    task automatic model_reset();
        t         = 0;
        ref_blank = 1'b0;
        owed_b    = 1'b0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 8'hFF;
    endtask

    function automatic obs_t predict();
        obs_t        o;
        int unsigned slot;
        int unsigned phase;
        slot    = (t / SD) % 8;
        phase   = t % SD;
        o.a_rdy = !reset && a_valid && (!b_valid || !owed_b);
        o.b_rdy = !reset && b_valid && (!a_valid || owed_b);
        o.scan  = 3'(slot);
        o.fd    = (t != 0) && ((t % (8 * SD)) == 0);
        o.seg   = (ref_blank || phase < BC) ? 8'hFF : ref_mem[slot];
        return o;
    endfunction

    // Inputs are already set; predict this cycle, then advance the model across the edge.
    task automatic step();
        exp_t e;
        e.v    = predict();
        e.scen = scen;
        e.t    = t;
        exp_q.push_back(e);
        a_fire = e.v.a_rdy;
        b_fire = e.v.b_rdy;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (a_fire) ref_mem[a_addr] = a_data;
            if (b_fire) ref_mem[b_addr] = b_data;
            if (a_valid && b_valid) owed_b = !owed_b;
            ref_blank = blank_all;
            t++;
        end
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        obs_t got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = '{a_rdy: a_ready, b_rdy: b_ready, seg: segout, scan: scanout,
                        fd: frame_done};
                n_cmp++;
                if (got !== e.v) begin
                    n_bad++;
                    $display("FAIL outputs scen%0d t=%0d: got rdy=%b%b seg=%h scan=%0d fd=%b, expected rdy=%b%b seg=%h scan=%0d fd=%b",
                             e.scen, e.t, got.a_rdy, got.b_rdy, got.seg, got.scan, got.fd,
                             e.v.a_rdy, e.v.b_rdy, e.v.seg, e.v.scan, e.v.fd);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: bench still running at %0t, required finished", $time);
        $fatal(1, "timeout");
    end

    initial begin : driver
        bit done;

        // 1: reset held with both requesters asking; nothing may be accepted.
        scen = 1;
        reset = 1'b1; blank_all = 1'b0;
        a_valid = 1'b1; a_addr = 3'd2; a_data = 8'h12;
        b_valid = 1'b1; b_addr = 3'd6; b_data = 8'h34;
        @(posedge clk);
        model_reset();
        #1;
        repeat (3) step();

        // 2: free run, blank buffer.
        scen = 2;
        reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        repeat (70) step();

        // 3: single A write to digit 3, then watch slot 3.
        scen = 3;
        a_valid = 1'b1; a_addr = 3'd3; a_data = 8'hC0;
        done = 1'b0;
        for (int k = 0; k < 16 && !done; k++) begin
            step();
            done = a_fire;
        end
        a_valid = 1'b0;
        repeat (80) step();

        // 4: sustained contention, each side reissuing on grant.
        scen = 4;
        a_valid = 1'b1; a_addr = 3'd0; a_data = 8'h01;
        b_valid = 1'b1; b_addr = 3'd1; b_data = 8'h02;
        repeat (10) step();
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (70) step();

        // 5: blank_all pulse inside slot 3.
        scen = 5;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            if ((t / SD) % 8 == 3 && t % SD == 3) done = 1'b1;
            else step();
        end
        blank_all = 1'b1;
        repeat (3) step();
        blank_all = 1'b0;
        repeat (20) step();

        // 6: leave rr pointing at B, reset with a pending A write, then contend again.
        scen = 6;
        a_valid = 1'b1; a_addr = 3'd4; a_data = 8'h44;
        b_valid = 1'b1; b_addr = 3'd4; b_data = 8'h77;
        step();
        reset = 1'b1; b_valid = 1'b0;
        a_addr = 3'd5; a_data = 8'h00;
        repeat (2) step();
        reset = 1'b0;
        a_addr = 3'd6; a_data = 8'h66;
        b_valid = 1'b1; b_addr = 3'd7; b_data = 8'h77;
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (70) step();

        // 7: randomized traffic, blanking and occasional resets.
        scen = 7;
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) == 0) blank_all = !blank_all;
            step();
            if (a_fire || !a_valid) begin
                a_valid = 1'($urandom_range(0, 1));
                a_addr  = 3'($urandom);
                a_data  = 8'($urandom);
            end
            if (b_fire || !b_valid) begin
                b_valid = 1'($urandom_range(0, 1));
                b_addr  = 3'($urandom);
                b_data  = 8'($urandom);
            end
        end
        reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0; blank_all = 1'b0;
        repeat (70) step();

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
